// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: round-robin share of one external LFSR between two burst requesters
module lfsr_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] len0,
  input  logic [CNT_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic [1:0]       done,
  output logic             err,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_sel,
  input  logic [WIDTH-1:0] lfsr_state
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;
  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             id_q, id_d, ptr_q, ptr_d, err_q, err_d;
  logic             win, lock, abort, reject;
  logic [WIDTH-1:0] win_seed;
  logic [CNT_W-1:0] win_len;
  assign win      = req[ptr_q] ? ptr_q : ~ptr_q;
  assign win_seed = win ? seed1 : seed0;
  assign win_len  = win ? len1 : len0;
  assign reject   = (win_seed == '0) || (win_len == '0);
  assign lock     = lfsr_state == '0;
  assign abort    = (state_q == LOAD || state_q == RUN) && !req[id_q];
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    seed_d  = seed_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    if (abort) begin
      state_d = IDLE;
      gnt_d   = 2'b00;
      ptr_d   = ~id_q;
    end else begin
      unique case (state_q)
        IDLE: if (req != 2'b00) begin
          seed_d  = win_seed;
          len_d   = win_len;
          id_d    = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          err_d   = reject;
          state_d = reject ? FIN : LOAD;
        end
        LOAD: begin
          state_d = RUN;
          cnt_d   = len_q;
        end
        RUN: begin
          // an all-zero LFSR state can never leave lock-up, so the burst ends in error
          state_d = (lock || cnt_q == CNT_W'(1)) ? FIN : RUN;
          err_d   = lock;
          cnt_d   = cnt_q - CNT_W'(1);
        end
        FIN: begin
          state_d = IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~id_q;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      seed_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      seed_q  <= seed_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end
  assign gnt       = gnt_q;
  assign busy      = state_q != IDLE;
  assign lfsr_sel  = state_q == RUN;
  assign lfsr_seed = seed_q;
  assign out_valid = lfsr_sel && !lock;
  assign out_data  = out_valid ? lfsr_state : '0;
  assign out_id    = id_q;
  assign done      = state_q == FIN ? (id_q ? 2'b10 : 2'b01) : 2'b00;
  assign err       = state_q == FIN && err_q;
endmodule
